// File: rtl/key_step_ctrl.sv
// Up/down key front end for a saturating parameter register: short press steps once,
// long press enters auto-repeat; pressing both keys cancels until everything is released.
module key_step_ctrl #(
  parameter int unsigned      VAL_W    = 8,
  parameter logic [VAL_W-1:0] VAL_MAX  = 8'd199,
  parameter logic [VAL_W-1:0] VAL_RST  = 8'd0,
  parameter int unsigned      CNT_W    = 25,
  parameter int unsigned      LONG_CYC = 25000000,
  parameter int unsigned      REP_CYC  = 5000000
) (
  input  logic             sys_clk,
  input  logic             sys_rstn,
  input  logic             key_up_n,
  input  logic             key_dn_n,
  input  logic             clear,
  output logic [VAL_W-1:0] value,
  output logic             step_pulse,
  output logic             dir,
  output logic             long_act,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

  typedef enum logic [1:0] {IDLE, PRESS, REPEAT, WAIT_REL} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic             sel_up_q, sel_up_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             long_q, long_d;
  logic             key_up_q, key_dn_q;
  logic             up_edge, dn_edge, act_n, oth_n, step_req;

  assign up_edge = !key_up_n && key_up_q;
  assign dn_edge = !key_dn_n && key_dn_q;
  // Level of the key that started the press, and of the key that would cancel it.
  assign act_n   = sel_up_q ? key_up_n : key_dn_n;
  assign oth_n   = sel_up_q ? key_dn_n : key_up_n;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_up_d = sel_up_q;
    step_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (up_edge && dn_edge) begin
          state_d = WAIT_REL;
        end else if (up_edge || dn_edge) begin
          state_d  = PRESS;
          sel_up_d = up_edge;
          cnt_d    = '0;
        end
      end
      PRESS: begin
        if (!oth_n) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end else if (act_n) begin
          step_req = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (cnt_q == LONG_LAST) begin
          step_req = 1'b1;
          state_d  = REPEAT;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!oth_n) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end else if (act_n) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          step_req = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_REL: begin
        if (key_up_n && key_dn_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A step at a limit is swallowed: no value change, no strobe, direction kept.
    value_d = value_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    if (step_req) begin
      if (sel_up_q && value_q < VAL_MAX) begin
        value_d = value_q + VAL_W'(1);
        dir_d   = 1'b1;
        step_d  = 1'b1;
      end else if (!sel_up_q && value_q != '0) begin
        value_d = value_q - VAL_W'(1);
        dir_d   = 1'b0;
        step_d  = 1'b1;
      end
    end

    if (clear) begin
      value_d = VAL_RST;
      step_d  = 1'b0;
      cnt_d   = '0;
      state_d = (!key_up_n || !key_dn_n) ? WAIT_REL : IDLE;
    end

    long_d = (state_d == REPEAT);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      value_q  <= VAL_RST;
      sel_up_q <= 1'b0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      long_q   <= 1'b0;
      key_up_q <= 1'b1;
      key_dn_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      sel_up_q <= sel_up_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      long_q   <= long_d;
      key_up_q <= key_up_n;
      key_dn_q <= key_dn_n;
    end
  end

  assign value      = value_q;
  assign step_pulse = step_q;
  assign dir        = dir_q;
  assign long_act   = long_q;
  assign at_max     = (value_q == VAL_MAX);
  assign at_min     = (value_q == '0);

endmodule
